// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared constants for the SAR ADC control slice.
//   SAR_TICK_MOD   : number of ticks in one conversion timebase period
//   SAR_TICK_W     : width of the tick counter
//   SAR_SAMPLE_END : tick on which the sample window closes (hold point)
//   SAR_FIRST_BIT  : tick of the first bit-trial slot
// No ports (package).
// -----------------------------------------------------------------------------
package sar_pkg;

   localparam int SAR_TICK_MOD   = 34;
   localparam int SAR_TICK_W     = $clog2(SAR_TICK_MOD);
   localparam int SAR_SAMPLE_END = 8;
   localparam int SAR_FIRST_BIT  = 9;

endpackage : sar_pkg

// File: rtl/up_counter_mod34.sv
// -----------------------------------------------------------------------------
// up_counter_mod34
// Free-running modulo-MODULUS up counter used as the SAR controller timebase.
// Counts 0..MODULUS-1 and wraps to 0; the controller restarts it by pulling
// reset low at the start of each conversion.
//
// Ports
//   clk   : in  1      rising-edge clock
//   reset : in  1      asynchronous active-low clear (0 = count forced to 0)
//   count : out WIDTH  current count, straight from the count register
//   tc    : out 1      terminal count, high while count == MODULUS-1
// -----------------------------------------------------------------------------
module up_counter_mod34
   import sar_pkg::*;
#(
   parameter int MODULUS = SAR_TICK_MOD,
   parameter int WIDTH   = SAR_TICK_W
)(
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   // Reject parameter sets that cannot represent every state.
   if (MODULUS < 2) begin : g_bad_modulus
      $error("up_counter_mod34: MODULUS must be >= 2");
   end
   if (WIDTH < 1 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
      $error("up_counter_mod34: 2**WIDTH must be >= MODULUS");
   end

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_next;

   // The compare comes before the increment, so the +1 never runs past the
   // top of WIDTH; anything at or beyond the last state (including corrupted
   // out-of-range values) returns to 0 on the next edge.
   assign w_count_next = (r_count >= LAST) ? ZERO : (r_count + ONE);

   // Count register: asynchronous clear, release taken on the next rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= ZERO;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign count = r_count;
   assign tc    = (r_count == LAST);

`ifdef ASSERT_ON
   a_count_in_range : assert property (
      @(posedge clk) disable iff (!reset) (r_count <= LAST));

   a_tc_matches_count : assert property (
      @(posedge clk) (tc == (r_count == LAST)));

   a_clear_after_reset : assert property (
      @(posedge clk) $fell(reset) |-> ##1 (r_count == ZERO));
`endif

endmodule : up_counter_mod34

// File: tb/tb_up_counter_mod34.sv
// -----------------------------------------------------------------------------
// tb_up_counter_mod34
// Directed, self-checking bench for up_counter_mod34 (default 34/6 build) plus
// two small parameterisations (2/1 and 16/4) sharing the same clock and reset.
// -----------------------------------------------------------------------------
module tb_up_counter_mod34;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] count;
   logic       tc;
   logic [0:0] count_m2;
   logic       tc_m2;
   logic [3:0] count_m16;
   logic       tc_m16;
   logic [4:0] sar_tick;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // SAR-style consumer that only looks at the low five bits.
   assign sar_tick = count[4:0];

   up_counter_mod34 u_dut (
      .clk   (clk),
      .reset (reset),
      .count (count),
      .tc    (tc)
   );

   up_counter_mod34 #(.MODULUS(2), .WIDTH(1)) u_m2 (
      .clk   (clk),
      .reset (reset),
      .count (count_m2),
      .tc    (tc_m2)
   );

   up_counter_mod34 #(.MODULUS(16), .WIDTH(4)) u_m16 (
      .clk   (clk),
      .reset (reset),
      .count (count_m16),
      .tc    (tc_m16)
   );

   // Pulse reset for one clock; on return count is 0 and the next edge gives 1.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [5:0] exp;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (count !== 6'd0 || tc !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: count=%0d tc=%0b expected count=0 tc=0", count, tc);
         end
      end
      reset = 1'b1;
      exp = 6'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp = exp + 6'd1;
         n_checks++;
         if (count !== exp) begin
            n_errors++;
            $display("FAIL reset_release: count=%0d expected %0d", count, exp);
         end
      end
   endtask

   task automatic test_wrap();
      logic [5:0] exp;
      time        t_last;
      int         n_tc;
      do_reset();
      exp    = 6'd0;
      t_last = 0;
      n_tc   = 0;
      for (int i = 0; i < 3 * 34; i++) begin
         @(negedge clk);
         exp = (exp == 6'd33) ? 6'd0 : exp + 6'd1;
         n_checks++;
         if (count !== exp || tc !== (exp == 6'd33)) begin
            n_errors++;
            $display("FAIL wrap_seq: count=%0d tc=%0b expected count=%0d tc=%0b",
                     count, tc, exp, (exp == 6'd33));
         end
         if (tc === 1'b1) begin
            if (n_tc > 0) begin
               n_checks++;
               if (($time - t_last) != 340) begin
                  n_errors++;
                  $display("FAIL wrap_period: got %0t expected 340", $time - t_last);
               end
            end
            t_last = $time;
            n_tc++;
         end
      end
      n_checks++;
      if (n_tc != 3) begin
         n_errors++;
         $display("FAIL wrap_tc_count: got %0d expected 3", n_tc);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (17) @(negedge clk);
      n_checks++;
      if (count !== 6'd17) begin
         n_errors++;
         $display("FAIL async_pre: count=%0d expected 17", count);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (count !== 6'd0 || tc !== 1'b0) begin
         n_errors++;
         $display("FAIL async_clear: count=%0d tc=%0b expected count=0 tc=0", count, tc);
      end
      @(negedge clk);
      n_checks++;
      if (count !== 6'd0) begin
         n_errors++;
         $display("FAIL async_hold: count=%0d expected 0", count);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (count !== 6'd1) begin
         n_errors++;
         $display("FAIL async_release: count=%0d expected 1", count);
      end
   endtask

   task automatic test_reset_at_tc();
      do_reset();
      repeat (33) @(negedge clk);
      n_checks++;
      if (count !== 6'd33 || tc !== 1'b1) begin
         n_errors++;
         $display("FAIL tc_pre: count=%0d tc=%0b expected count=33 tc=1", count, tc);
      end
      @(posedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (count !== 6'd0 || tc !== 1'b0) begin
         n_errors++;
         $display("FAIL tc_edge_reset: count=%0d tc=%0b expected count=0 tc=0", count, tc);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (count !== 6'd0 || tc !== 1'b0) begin
            n_errors++;
            $display("FAIL tc_reset_hold: count=%0d tc=%0b expected count=0 tc=0", count, tc);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (count !== 6'd1) begin
         n_errors++;
         $display("FAIL tc_release: count=%0d expected 1", count);
      end
   endtask

   task automatic test_truncated();
      logic [5:0] exp;
      logic [4:0] exp_tick;
      int         hits8;
      int         hits9;
      do_reset();
      exp   = 6'd0;
      hits8 = 0;
      hits9 = 0;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         exp      = (exp == 6'd33) ? 6'd0 : exp + 6'd1;
         exp_tick = exp[4:0];
         n_checks++;
         if (sar_tick !== exp_tick) begin
            n_errors++;
            $display("FAIL trunc_seq: tick=%0d expected %0d", sar_tick, exp_tick);
         end
         if (sar_tick === 5'd8) hits8++;
         if (sar_tick === 5'd9) hits9++;
      end
      n_checks++;
      if (hits8 != 1 || hits9 != 1) begin
         n_errors++;
         $display("FAIL trunc_ticks: hits8=%0d hits9=%0d expected 1 and 1", hits8, hits9);
      end
   endtask

   task automatic test_params();
      logic [0:0] e2;
      logic [3:0] e16;
      do_reset();
      e2  = 1'b0;
      e16 = 4'd0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         e2  = ~e2;
         e16 = (e16 == 4'd15) ? 4'd0 : e16 + 4'd1;
         n_checks++;
         if (count_m2 !== e2 || tc_m2 !== e2[0]) begin
            n_errors++;
            $display("FAIL mod2: count=%0d tc=%0b expected count=%0d tc=%0b",
                     count_m2, tc_m2, e2, e2[0]);
         end
         n_checks++;
         if (count_m16 !== e16 || tc_m16 !== (e16 == 4'd15)) begin
            n_errors++;
            $display("FAIL mod16: count=%0d tc=%0b expected count=%0d tc=%0b",
                     count_m16, tc_m16, e16, (e16 == 4'd15));
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_wrap();
      test_async_reset();
      test_reset_at_tc();
      test_truncated();
      test_params();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_up_counter_mod34
